see_cone_campaign: RTL

// Parametrised SEE fault-campaign sequencer for extracted logic cones. Drives one stimulus

---
 rtl/see_cone_campaign.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/see_cone_campaign.sv
// SEE fault-campaign sequencer: drives vectors into a golden/faulty cone pair,
// compares their outputs at the end of each hold window and accumulates error statistics.
module see_cone_campaign #(
    parameter int unsigned N_IN      = 9,
    parameter int unsigned N_OUT     = 1,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned HOLD      = 2,
    parameter logic [N_IN-1:0] LFSR_TAPS = N_IN'(9'h110)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [N_IN-1:0]   seed,
    input  logic [CNT_W-1:0]  num_vectors,
    input  logic [N_OUT-1:0]  golden_out,
    input  logic [N_OUT-1:0]  faulty_out,
    output logic [N_IN-1:0]   stim,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  vec_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [N_OUT-1:0]  err_mask,
    output logic [N_IN-1:0]   first_err_vec,
    output logic              first_err_vld
);

    localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [N_IN-1:0]    stim_q, stim_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [N_OUT-1:0]   mask_q, mask_d;
    logic [N_IN-1:0]    fvec_q, fvec_d;
    logic               fvld_q, fvld_d;

    logic [N_OUT-1:0]   diff;
    logic [N_IN-1:0]    stim_next;

    assign diff      = golden_out ^ faulty_out;
    assign stim_next = mode_q ? {stim_q[N_IN-2:0], ^(stim_q & LFSR_TAPS)}
                              : stim_q + N_IN'(1);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        mode_d  = mode_q;
        num_d   = num_q;
        stim_d  = stim_q;
        vec_d   = vec_q;
        err_d   = err_q;
        mask_d  = mask_q;
        fvec_d  = fvec_q;
        fvld_d  = fvld_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    num_d  = num_vectors;
                    hold_d = '0;
                    vec_d  = '0;
                    err_d  = '0;
                    mask_d = '0;
                    fvec_d = '0;
                    fvld_d = 1'b0;
                    if (num_vectors != '0) begin
                        // An all-zero LFSR state would lock up, so substitute 1
                        stim_d  = (mode && seed == '0) ? N_IN'(1) : seed;
                        state_d = S_APPLY;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_APPLY: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (hold_q == HOLD_W'(HOLD - 1)) begin
                    hold_d = '0;
                    vec_d  = vec_q + CNT_W'(1);
                    if (diff != '0) begin
                        if (err_q != '1) err_d = err_q + CNT_W'(1);
                        mask_d = mask_q | diff;
                        if (!fvld_q) begin
                            fvec_d = stim_q;
                            fvld_d = 1'b1;
                        end
                    end
                    if (vec_d == num_q) state_d = S_DONE;
                    else                stim_d  = stim_next;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_APPLY);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            mode_q  <= 1'b0;
            num_q   <= '0;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vec_q   <= '0;
            err_q   <= '0;
            mask_q  <= '0;
            fvec_q  <= '0;
            fvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            mode_q  <= mode_d;
            num_q   <= num_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            fvec_q  <= fvec_d;
            fvld_q  <= fvld_d;
        end
    end

    assign stim          = stim_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign vec_count     = vec_q;
    assign err_count     = err_q;
    assign err_mask      = mask_q;
    assign first_err_vec = fvec_q;
    assign first_err_vld = fvld_q;

endmodule
